// File: rtl/input_controller.sv
// rtl/input_controller.sv - debounced pushbutton front end issuing one-hot game commands
//
// Purpose:
//   Synchronizes and debounces the three active-low DE2 pushbuttons
//   (HIT, STAND, NEW GAME), turns each debounced press into exactly one
//   command and offers it to the game FSM over a valid/ready handshake.
//   Also drives the debounced pressed levels for status LEDs.
//
// Ports:
//   i_clk            system clock (50 MHz)
//   i_rst_n          asynchronous reset, active-low
//   i_key_hit_n      raw HIT button, asynchronous, 0 = pressed
//   i_key_stand_n    raw STAND button, asynchronous, 0 = pressed
//   i_key_new_n      raw NEW GAME button, asynchronous, 0 = pressed
//   i_cmd_ready      game FSM can take a command this cycle
//   o_cmd_valid      a command is offered
//   o_cmd_hit        offered command is HIT
//   o_cmd_stand      offered command is STAND
//   o_cmd_new_game   offered command is NEW GAME
//   o_overrun        one-cycle pulse: at least one press was dropped
//   o_btn_down       debounced pressed levels {new, stand, hit}

module input_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_hit_n,
  input  logic       i_key_stand_n,
  input  logic       i_key_new_n,
  input  logic       i_cmd_ready,
  output logic       o_cmd_valid,
  output logic       o_cmd_hit,
  output logic       o_cmd_stand,
  output logic       o_cmd_new_game,
  output logic       o_overrun,
  output logic [2:0] o_btn_down
);

  // Key index order everywhere: [2] = new game, [1] = stand, [0] = hit.
  localparam int KEYS = 3;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  logic [KEYS-1:0]  w_raw_n;
  logic [KEYS-1:0]  r_sync1;
  logic [KEYS-1:0]  r_sync2;
  logic [KEYS-1:0]  r_stable;
  logic [KEYS-1:0]  r_stable_d;
  logic [KEYS-1:0]  r_btn_down;
  logic [CNT_W-1:0] r_count [KEYS];

  logic [KEYS-1:0]  w_event;
  logic [KEYS-1:0]  w_pick;
  logic             w_multi;

  state_t           r_state;
  logic             r_valid;
  logic             r_overrun;
  logic [KEYS-1:0]  r_cmd;

  assign w_raw_n = {i_key_new_n, i_key_stand_n, i_key_hit_n};

  // Two-flop synchronizer; only r_sync2 feeds the debouncer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw_n;
      r_sync2 <= r_sync1;
    end
  end

  // Per-key debounce: the synchronized level must disagree with the stable
  // level on DEBOUNCE_CYCLES consecutive edges before it is accepted. Any
  // agreement in between restarts the count, which swallows bounces.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable   <= '1;
      r_stable_d <= '1;
      r_btn_down <= '0;
      for (int k = 0; k < KEYS; k++) begin
        r_count[k] <= '0;
      end
    end else begin
      r_stable_d <= r_stable;
      r_btn_down <= ~r_stable;
      for (int k = 0; k < KEYS; k++) begin
        if (r_sync2[k] == r_stable[k]) begin
          r_count[k] <= '0;
        end else if (r_count[k] == LIMIT) begin
          r_stable[k] <= r_sync2[k];
          r_count[k]  <= '0;
        end else begin
          r_count[k] <= r_count[k] + CNT_W'(1);
        end
      end
    end
  end

  // Press = falling edge of the stable level; releases are ignored.
  assign w_event = r_stable_d & ~r_stable;

  // Highest-priority event: new game > stand > hit.
  always_comb begin
    w_pick = '0;
    if (w_event[2]) begin
      w_pick = 3'b100;
    end else if (w_event[1]) begin
      w_pick = 3'b010;
    end else if (w_event[0]) begin
      w_pick = 3'b001;
    end
  end

  // More than one simultaneous event means the lower ones are lost.
  assign w_multi = (w_event[0] & w_event[1]) |
                   (w_event[0] & w_event[2]) |
                   (w_event[1] & w_event[2]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_cmd     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_event) begin
            r_cmd     <= w_pick;
            r_valid   <= 1'b1;
            r_state   <= S_PENDING;
            r_overrun <= w_multi;
          end
        end
        S_PENDING: begin
          if (i_cmd_ready) begin
            // Accepted; an event in the same cycle follows with no gap.
            if (|w_event) begin
              r_cmd     <= w_pick;
              r_overrun <= w_multi;
            end else begin
              r_cmd   <= '0;
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (|w_event) begin
            // Something is always lost here: either the new event or, when
            // new game preempts, the command it replaces.
            r_overrun <= 1'b1;
            if (w_event[2]) begin
              r_cmd <= 3'b100;
            end
          end
        end
      endcase
    end
  end

  assign o_cmd_valid    = r_valid;
  assign o_cmd_new_game = r_cmd[2];
  assign o_cmd_stand    = r_cmd[1];
  assign o_cmd_hit      = r_cmd[0];
  assign o_overrun      = r_overrun;
  assign o_btn_down     = r_btn_down;

endmodule

// File: doc/input_controller.md
Name: input_controller

Overview:
- Player-input front end for the blackjack game. It is the input-side counterpart of the hex-display output path.
- Takes three raw active-low DE2 pushbuttons (HIT, STAND, NEW GAME) and synchronizes and debounces each one.
- Turns each debounced press into exactly one command, offered to the game FSM over a valid/ready handshake.
- Also drives debounced button levels for status LEDs.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized level must differ from the stable level before it is accepted (10 ms at 50 MHz); must be at least 2.
- CNT_W, 19, debounce counter width; 2^CNT_W must be at least DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous reset, active-low
- key_hit_n  in  1  raw HIT button, asynchronous, 0 = pressed
- key_stand_n  in  1  raw STAND button, asynchronous, 0 = pressed
- key_new_n  in  1  raw NEW GAME button, asynchronous, 0 = pressed
- cmd_ready  in  1  game FSM can take a command this cycle
- cmd_valid  out  1  a command is offered
- cmd_hit  out  1  offered command is HIT (one-hot with the next two; all 0 when cmd_valid=0)
- cmd_stand  out  1  offered command is STAND
- cmd_new_game  out  1  offered command is NEW GAME
- overrun  out  1  one-cycle pulse: a press was dropped
- btn_down  out  3  debounced pressed levels {new, stand, hit}

Behaviour:
- Reset, asynchronous, all state:
  - Synchronizer flops = 1; stable levels and their delayed copies = 1; counters = 0.
  - cmd_valid = 0, cmd_* = 0, overrun = 0, btn_down = 3'b000.
  - Asserting reset mid-press or mid-handshake discards everything.
  - After release, a key already held low must be debounced afresh, then produces one command.
- Synchronizer: two flops per key; only the second-flop output (sync) is used.
- Debounce, per key, independent:
  - sync == stable: count <= 0.
  - sync != stable and count == DEBOUNCE_CYCLES-1: stable <= sync, count <= 0.
  - Otherwise: count <= count+1.
  - Any return to the stable level before the limit clears the count, so bounces shorter than DEBOUNCE_CYCLES are ignored.
- Press event: stable_d == 1 and stable == 0, where stable_d is stable delayed one cycle. Release events are ignored. A held key yields one event per press.
- Latency: raw low first sampled at edge 0 means stable falls at edge DEBOUNCE_CYCLES+1 and cmd_valid rises at edge DEBOUNCE_CYCLES+2.
- btn_down = ~stable, one cycle after the stable update.
- Command FSM, IDLE / PENDING:
  - IDLE, any event(s): load the one-hot cmd, go to PENDING. Priority is new_game > stand > hit; lower-priority simultaneous events are dropped and overrun pulses.
  - PENDING: cmd_valid = 1, and cmd_* stay constant unless preempted.
  - Handshake completes in the cycle cmd_valid && cmd_ready. Next state is IDLE with cmd_valid = 0, unless an event occurs in that same cycle; then the new cmd loads and cmd_valid stays 1 (back-to-back commands, no gap).
  - PENDING without ready, new_game event while the pending cmd is hit/stand: cmd is replaced by new_game, cmd_valid stays 1, overrun pulses.
  - PENDING without ready, any other event: dropped, overrun pulses, pending cmd unchanged.
  - cmd_ready while in IDLE has no effect.
- overrun: registered, asserted for exactly one cycle per dropping cycle, however many events were dropped in it.

Test Plan:
- (All with DEBOUNCE_CYCLES=4.)
- Reset: rst_n=0 with keys random -> all outputs 0, btn_down=000. Then release reset with keys high -> outputs unchanged for 20 cycles.
- Clean HIT press: key_hit_n low from edge 0, cmd_ready=0 -> btn_down=001 after edge 6 and cmd_valid=1, cmd_hit=1 after edge 6. Values hold for 10 cycles. Then cmd_ready=1 for one cycle -> cmd_valid=0 on the next edge. Keep the key held for 50 cycles -> no second command.
- Bounce: key_stand_n toggles low 3 cycles / high 1 cycle, repeated 5 times, then stays high -> no event, cmd_valid stays 0, btn_down stays 000.
- Priority: hit and new_game go low on the same edge -> cmd_new_game=1, cmd_hit=0, overrun pulses exactly 1 cycle.
- Preempt: HIT pending with cmd_ready=0, then new_game pressed -> cmd_new_game=1, cmd_valid never drops, overrun=1 for one cycle. A STAND press afterward -> dropped, overrun pulses, cmd stays new_game.
- Back-to-back and reset mid-op: the STAND event lands in the same cycle as HIT acceptance -> cmd_stand=1 with no gap. Assert rst_n=0 while PENDING -> cmd_valid=0 immediately (asynchronous).
